// File: rtl/ball_motion.sv
// Breakout ball: per-frame motion with wall/paddle/brick bounces, loss detection and a registered pixel mask.
// Optional BALL_SPEEDUP_EN: speed rises by one every 4th paddle bounce, saturating at MAX_SPEED.
module ball_motion #(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned START_X   = 316,
  parameter int unsigned START_Y   = 440,
  parameter int unsigned PADDLE_Y  = 464,
  parameter int unsigned PADDLE_W  = 64,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned MAX_SPEED = 5
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [9:0] hpos,
  input  logic [8:0] vpos,
  input  logic       active,
  input  logic       frame_pulse,
  input  logic [9:0] paddle_x,
  input  logic       launch,
  input  logic       brick_hit,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       ball_pixel,
  output logic       ball_lost
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 11;
  localparam int unsigned SW = $clog2(((SPEED > MAX_SPEED) ? SPEED : MAX_SPEED) + 1);

  localparam logic [CW-1:0] C_BS    = CW'(BALL_SIZE);
  localparam logic [CW-1:0] C_X_MAX = CW'(SCREEN_W - BALL_SIZE);
  localparam logic [CW-1:0] C_Y_MAX = CW'(SCREEN_H - BALL_SIZE);
  localparam logic [CW-1:0] C_PY    = CW'(PADDLE_Y);
  localparam logic [CW-1:0] C_PW    = CW'(PADDLE_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_LOST   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XW-1:0]   r_ball_x, w_x_nxt;
  logic [YW-1:0]   r_ball_y, w_y_nxt;
  logic            r_dx_pos, w_dx_pos_nxt;
  logic            r_dy_up, w_dy_up_nxt;
  logic            r_hit_pending, w_hit_nxt;
  logic            r_ball_pixel, w_pix_nxt;
  logic            r_ball_lost, w_lost_nxt;

  logic [SW-1:0]   w_speed;
  logic [CW-1:0]   w_x, w_y, w_s, w_px;
  logic            w_dy_up_eff;
  logic            w_paddle_hit;

  assign w_x  = CW'(r_ball_x);
  assign w_y  = CW'(r_ball_y);
  assign w_s  = CW'(w_speed);
  assign w_px = CW'(paddle_x);

  // Direction used by this frame's update: a pending brick hit flips it first
  assign w_dy_up_eff = r_dy_up ^ (r_hit_pending | brick_hit);

  assign w_paddle_hit = (w_y + C_BS <= C_PY) && (w_y + C_BS + w_s >= C_PY) &&
                        (w_x + C_BS > w_px) && (w_x < w_px + C_PW);

  assign w_pix_nxt = active && (r_state != S_LOST) &&
                     (CW'(hpos) >= w_x) && (CW'(hpos) < w_x + C_BS) &&
                     (CW'(vpos) >= w_y) && (CW'(vpos) < w_y + C_BS);

`ifdef BALL_SPEEDUP_EN
  logic [SW-1:0] r_speed, w_speed_nxt;
  logic [1:0]    r_hit_cnt, w_cnt_nxt;

  assign w_speed = r_speed;

  // Count paddle bounces; every 4th one bumps the speed up to the ceiling
  always_comb begin
    w_speed_nxt = r_speed;
    w_cnt_nxt   = r_hit_cnt;
    if ((r_state == S_IDLE) && launch) begin
      w_speed_nxt = SW'(SPEED);
      w_cnt_nxt   = 2'd0;
    end else if ((r_state == S_MOVING) && frame_pulse && !w_dy_up_eff && w_paddle_hit) begin
      w_cnt_nxt = r_hit_cnt + 2'd1;
      if ((r_hit_cnt == 2'd3) && (r_speed < SW'(MAX_SPEED))) begin
        w_speed_nxt = r_speed + SW'(1);
      end
    end
  end
`else
  assign w_speed = SW'(SPEED);
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state       <= S_IDLE;
      r_ball_x      <= XW'(START_X);
      r_ball_y      <= YW'(START_Y);
      r_dx_pos      <= 1'b1;
      r_dy_up       <= 1'b1;
      r_hit_pending <= 1'b0;
      r_ball_pixel  <= 1'b0;
      r_ball_lost   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      r_speed       <= SW'(SPEED);
      r_hit_cnt     <= 2'd0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ball_x      <= w_x_nxt;
      r_ball_y      <= w_y_nxt;
      r_dx_pos      <= w_dx_pos_nxt;
      r_dy_up       <= w_dy_up_nxt;
      r_hit_pending <= w_hit_nxt;
      r_ball_pixel  <= w_pix_nxt;
      r_ball_lost   <= w_lost_nxt;
`ifdef BALL_SPEEDUP_EN
      r_speed       <= w_speed_nxt;
      r_hit_cnt     <= w_cnt_nxt;
`endif
    end
  end

  // Next-state and per-frame motion
  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_ball_x;
    w_y_nxt      = r_ball_y;
    w_dx_pos_nxt = r_dx_pos;
    w_dy_up_nxt  = r_dy_up;
    w_hit_nxt    = r_hit_pending;
    w_lost_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_hit_nxt = 1'b0;
        if (launch) begin
          w_state_nxt  = S_MOVING;
          w_dx_pos_nxt = 1'b1;
          w_dy_up_nxt  = 1'b1;
        end
      end

      S_MOVING: begin
        if (frame_pulse) begin
          w_hit_nxt   = 1'b0;
          w_dy_up_nxt = w_dy_up_eff;

          if (!r_dx_pos && (w_x < w_s)) begin
            w_x_nxt      = '0;
            w_dx_pos_nxt = 1'b1;
          end else if (r_dx_pos && (w_x + w_s >= C_X_MAX)) begin
            w_x_nxt      = XW'(C_X_MAX);
            w_dx_pos_nxt = 1'b0;
          end else if (r_dx_pos) begin
            w_x_nxt = XW'(w_x + w_s);
          end else begin
            w_x_nxt = XW'(w_x - w_s);
          end

          if (w_dy_up_eff) begin
            if (w_y < w_s) begin
              w_y_nxt     = '0;
              w_dy_up_nxt = 1'b0;
            end else begin
              w_y_nxt = YW'(w_y - w_s);
            end
          end else if (w_paddle_hit) begin
            w_y_nxt     = YW'(C_PY - C_BS);
            w_dy_up_nxt = 1'b1;
          end else if (w_y + w_s >= C_Y_MAX) begin
            // Ball leaves the bottom: freeze where it was
            w_state_nxt  = S_LOST;
            w_lost_nxt   = 1'b1;
            w_x_nxt      = r_ball_x;
            w_y_nxt      = r_ball_y;
            w_dx_pos_nxt = r_dx_pos;
            w_dy_up_nxt  = r_dy_up;
          end else begin
            w_y_nxt = YW'(w_y + w_s);
          end
        end else if (brick_hit) begin
          w_hit_nxt = 1'b1;
        end
      end

      S_LOST: begin
        w_hit_nxt = 1'b0;
        if (frame_pulse) begin
          w_state_nxt  = S_IDLE;
          w_x_nxt      = XW'(START_X);
          w_y_nxt      = YW'(START_Y);
          w_dx_pos_nxt = 1'b1;
          w_dy_up_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_hit_nxt   = 1'b0;
      end
    endcase
  end

  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign ball_pixel = r_ball_pixel;
  assign ball_lost  = r_ball_lost;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: parking, launch, walls, bricks, paddle, loss and mid-flight reset.
module tb_ball_motion;

  logic       clk;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       active;
  logic       frame_pulse;
  logic [9:0] paddle_x;
  logic       launch;
  logic       brick_hit;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       ball_pixel;
  logic       ball_lost;

  int n_checks = 0;
  int n_bad    = 0;
  int lost_cnt = 0;

  ball_motion dut (
    .clk         (clk),
    .nRst        (nRst),
    .hpos        (hpos),
    .vpos        (vpos),
    .active      (active),
    .frame_pulse (frame_pulse),
    .paddle_x    (paddle_x),
    .launch      (launch),
    .brick_hit   (brick_hit),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_pixel  (ball_pixel),
    .ball_lost   (ball_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (ball_lost === 1'b1) lost_cnt++;
  endtask

  task automatic frame();
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    step();
  endtask

  task automatic frame_with_hit();
    frame_pulse = 1'b1;
    brick_hit   = 1'b1;
    step();
    frame_pulse = 1'b0;
    brick_hit   = 1'b0;
    step();
  endtask

  task automatic do_launch();
    launch = 1'b1;
    step();
    launch = 1'b0;
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic act, input logic exp);
    hpos   = 10'(h);
    vpos   = 9'(v);
    active = act;
    step();
    check(tag, 32'(ball_pixel), 32'(exp));
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(ball_x), 32'(x));
    check({tag, "_y"}, 32'(ball_y), 32'(y));
  endtask

  initial begin
    nRst = 1'b0; hpos = '0; vpos = '0; active = 1'b0; frame_pulse = 1'b0;
    paddle_x = '0; launch = 1'b0; brick_hit = 1'b0;
    step(); step();
    check_pos("reset", 316, 440);
    check("reset_pixel", 32'(ball_pixel), 32'd0);
    check("reset_lost", 32'(ball_lost), 32'd0);
    nRst = 1'b1;
    step();

    // Parked ball ignores frame pulses
    frame(); frame(); frame();
    check_pos("parked", 316, 440);
    check("parked_lost", 32'(ball_lost), 32'd0);
    pix("pix_tl", 316, 440, 1'b1, 1'b1);
    pix("pix_br", 323, 447, 1'b1, 1'b1);
    pix("pix_left", 315, 440, 1'b1, 1'b0);
    pix("pix_right", 324, 440, 1'b1, 1'b0);
    pix("pix_above", 316, 439, 1'b1, 1'b0);
    pix("pix_below", 316, 448, 1'b1, 1'b0);
    pix("pix_blank", 318, 442, 1'b0, 1'b0);

    // One-cycle latency: output holds until the next edge
    pix("pix_lat_on", 316, 440, 1'b1, 1'b1);
    hpos = 10'd324;
    #1;
    check("pix_lat_hold", 32'(ball_pixel), 32'd1);
    step();
    check("pix_lat_off", 32'(ball_pixel), 32'd0);

    do_launch();
    frame();
    check_pos("launch1", 318, 438);
    pix("pix_moved_in", 318, 438, 1'b1, 1'b1);
    pix("pix_moved_out", 317, 440, 1'b1, 1'b0);

    for (int i = 0; i < 119; i++) frame();
    check_pos("up120", 556, 200);

    // Brick hit mid-frame flips dy at the next update
    brick_hit = 1'b1; step(); brick_hit = 1'b0; step();
    check_pos("brick_wait", 556, 200);
    frame();
    check_pos("brick_mid", 558, 202);
    frame();
    check_pos("brick_cont", 560, 204);
    frame_with_hit();
    check_pos("brick_same", 562, 202);

    for (int i = 0; i < 34; i++) frame();
    check_pos("near_wall", 630, 134);
    frame();
    check_pos("wall_clamp", 632, 132);
    frame();
    check_pos("wall_back", 630, 130);

    // Reset during flight parks the ball immediately
    nRst = 1'b0;
    step();
    check_pos("midreset", 316, 440);
    nRst = 1'b1;
    step();
    frame();
    check_pos("midreset_idle", 316, 440);

    // Paddle bounce
    paddle_x = 10'd300;
    do_launch();
    frame_with_hit();
    check_pos("down1", 318, 442);
    for (int i = 0; i < 6; i++) frame();
    check_pos("pre_paddle", 330, 454);
    frame();
    check_pos("paddle_hit", 332, 456);
    frame();
    check_pos("paddle_up", 334, 454);

    // Miss the paddle and lose the ball
    nRst = 1'b0; step(); nRst = 1'b1; step();
    paddle_x = 10'd0;
    lost_cnt = 0;
    do_launch();
    frame_with_hit();
    check_pos("miss_down", 318, 442);
    for (int i = 0; i < 14; i++) frame();
    check_pos("miss_low", 346, 470);
    check("no_early_lost", 32'(lost_cnt), 32'd0);
    hpos = 10'd346; vpos = 9'd470; active = 1'b1;
    frame_pulse = 1'b1;
    step();
    frame_pulse = 1'b0;
    check("lost_pulse", 32'(ball_lost), 32'd1);
    check_pos("lost_frozen", 346, 470);
    step();
    check("lost_pulse_end", 32'(ball_lost), 32'd0);
    check("lost_no_pixel", 32'(ball_pixel), 32'd0);
    do_launch();
    step(); step();
    frame();
    check_pos("lost_to_idle", 316, 440);
    frame();
    check_pos("idle_after_lost", 316, 440);
    check("lost_pulse_count", 32'(lost_cnt), 32'd1);
    pix("pix_idle_again", 316, 440, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
